// File: rtl/ant_sim_pkg.sv
// Shared constants and types for the ant simulation environment.
// Holds the environment geometry and the location scanner's state/mode encodings.
package ant_sim_pkg;

    localparam int PIXELS_X = 640;
    localparam int PIXELS_Y = 480;
    localparam int X_BITS   = $clog2(PIXELS_X);
    localparam int Y_BITS   = $clog2(PIXELS_Y);

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

    typedef enum logic {
        SCAN_SINGLE,
        SCAN_CONT
    } scan_mode_t;

    // Bounds check done in 32 bits so an out-of-range max never aliases into range.
    function automatic logic bounds_legal(input int unsigned lo, input int unsigned hi,
                                          input int unsigned limit);
        return (lo <= hi) && (hi < limit);
    endfunction

endpackage

// File: rtl/scan_axis_counter.sv
// One coordinate axis of the location scanner: loadable up-counter with a
// compare-to-max flag, so wrapping is decided by the owner rather than by overflow.
module scan_axis_counter #(
    parameter int WIDTH = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] value,
    output logic             at_max
);

    logic [WIDTH-1:0] value_q;

    // Load has priority so a wrap back to the window minimum beats the increment.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_val;
        end else if (inc) begin
            value_q <= value_q + 1'b1;
        end
    end

    assign value  = value_q;
    assign at_max = (value_q == max_val);

endmodule

// File: rtl/loc_scanner.sv
// Raster-order location generator over a programmable window with a valid/ready
// output, single-frame or free-running continuous scanning, abort and config error.
module loc_scanner #(
    parameter int PIXELS_X = ant_sim_pkg::PIXELS_X,
    parameter int PIXELS_Y = ant_sim_pkg::PIXELS_Y,
    parameter int X_BITS   = $clog2(PIXELS_X),
    parameter int Y_BITS   = $clog2(PIXELS_Y)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [X_BITS-1:0] x_min,
    input  logic [X_BITS-1:0] x_max,
    input  logic [Y_BITS-1:0] y_min,
    input  logic [Y_BITS-1:0] y_max,
    output logic [X_BITS-1:0] loc_x,
    output logic [Y_BITS-1:0] loc_y,
    output logic              loc_valid,
    input  logic              loc_ready,
    output logic              row_last,
    output logic              frame_last,
    output logic              frame_done,
    output logic              busy,
    output logic              cfg_err
);

    import ant_sim_pkg::*;

    scan_state_t       state_q;
    scan_mode_t        mode_q;
    logic [X_BITS-1:0] xMin_q, xMax_q;
    logic [Y_BITS-1:0] yMin_q, yMax_q;
    logic              frameDone_q;
    logic              cfgErr_q;

    logic scanning, accept, windowLegal, startLoad, singleEnd;
    logic xAtMax, yAtMax, rowLast, frameLast;
    logic xLoad, xInc, yLoad, yInc;
    logic [X_BITS-1:0] xLoadVal;
    logic [Y_BITS-1:0] yLoadVal;

    assign scanning    = (state_q == SCAN);
    assign accept      = scanning & loc_ready & ~abort;
    assign windowLegal = bounds_legal(32'(x_min), 32'(x_max), PIXELS_X) &
                         bounds_legal(32'(y_min), 32'(y_max), PIXELS_Y);
    assign startLoad   = ~scanning & start & ~abort & windowLegal;
    assign rowLast     = scanning & xAtMax;
    assign frameLast   = rowLast & yAtMax;
    assign singleEnd   = frameLast & (mode_q == SCAN_SINGLE);

    // A finished single frame leaves both counters holding the last location.
    assign xLoad    = startLoad | (accept & rowLast & ~singleEnd);
    assign xLoadVal = startLoad ? x_min : xMin_q;
    assign xInc     = accept & ~rowLast;
    assign yLoad    = startLoad | (accept & frameLast & (mode_q == SCAN_CONT));
    assign yLoadVal = startLoad ? y_min : yMin_q;
    assign yInc     = accept & rowLast & ~frameLast;

    scan_axis_counter #(.WIDTH(X_BITS)) xAxis (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (xLoad),
        .load_val (xLoadVal),
        .inc      (xInc),
        .max_val  (xMax_q),
        .value    (loc_x),
        .at_max   (xAtMax)
    );

    scan_axis_counter #(.WIDTH(Y_BITS)) yAxis (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (yLoad),
        .load_val (yLoadVal),
        .inc      (yInc),
        .max_val  (yMax_q),
        .value    (loc_y),
        .at_max   (yAtMax)
    );

    // Abort always wins: it blocks a start in IDLE and suppresses frame_done in SCAN.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            mode_q      <= SCAN_SINGLE;
            xMin_q      <= '0;
            xMax_q      <= '0;
            yMin_q      <= '0;
            yMax_q      <= '0;
            frameDone_q <= 1'b0;
            cfgErr_q    <= 1'b0;
        end else begin
            frameDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        if (windowLegal) begin
                            xMin_q   <= x_min;
                            xMax_q   <= x_max;
                            yMin_q   <= y_min;
                            yMax_q   <= y_max;
                            mode_q   <= scan_mode_t'(mode);
                            cfgErr_q <= 1'b0;
                            state_q  <= SCAN;
                        end else begin
                            cfgErr_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (accept && frameLast) begin
                        frameDone_q <= 1'b1;
                        if (mode_q == SCAN_SINGLE) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign loc_valid  = scanning;
    assign busy       = scanning;
    assign row_last   = rowLast;
    assign frame_last = frameLast;
    assign frame_done = frameDone_q;
    assign cfg_err    = cfgErr_q;

endmodule

// File: tb/tb_loc_scanner.sv
// Self-checking bench for loc_scanner: directed scenarios plus randomized traffic,
// compared every cycle against a window-index reference model.
module tb_loc_scanner;

    localparam int PX = 640;
    localparam int PY = 480;
    localparam int XB = $clog2(PX);
    localparam int YB = $clog2(PY);

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mode = 1'b0;
    logic [XB-1:0] x_min = '0, x_max = '0;
    logic [YB-1:0] y_min = '0, y_max = '0;
    logic [XB-1:0] loc_x;
    logic [YB-1:0] loc_y;
    logic          loc_valid, loc_ready = 1'b0;
    logic          row_last, frame_last, frame_done, busy, cfg_err;

    int checkCount = 0;
    int errorCount = 0;

    // Requested window and mode driven on the next start
    int curXmin, curXmax, curYmin, curYmax;
    bit curMode;

    // Reference model: a scan is a linear index into a W x H window
    bit mScan, mMode, mCfgErr, mFrameDone;
    int mIdx, mW, mH, mXmin, mYmin, mX, mY;

    loc_scanner dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .x_min      (x_min),
        .x_max      (x_max),
        .y_min      (y_min),
        .y_max      (y_max),
        .loc_x      (loc_x),
        .loc_y      (loc_y),
        .loc_valid  (loc_valid),
        .loc_ready  (loc_ready),
        .row_last   (row_last),
        .frame_last (frame_last),
        .frame_done (frame_done),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit rst, input bit st, input bit ab, input bit rdy);
        if (rst) begin
            mScan = 0; mIdx = 0; mCfgErr = 0; mFrameDone = 0; mX = 0; mY = 0;
        end else begin
            mFrameDone = 0;
            if (mScan) begin
                if (ab) begin
                    mScan = 0;
                end else if (rdy) begin
                    if (mIdx == mW * mH - 1) begin
                        mFrameDone = 1;
                        if (mMode) mIdx = 0;
                        else mScan = 0;
                    end else begin
                        mIdx++;
                    end
                end
            end else if (st && !ab) begin
                if (curXmin <= curXmax && curXmax < PX && curYmin <= curYmax && curYmax < PY) begin
                    mScan = 1; mIdx = 0; mMode = curMode; mCfgErr = 0;
                    mW = curXmax - curXmin + 1; mH = curYmax - curYmin + 1;
                    mXmin = curXmin; mYmin = curYmin;
                end else begin
                    mCfgErr = 1;
                end
            end
            if (mScan) begin
                mX = mXmin + mIdx % mW;
                mY = mYmin + mIdx / mW;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("loc_valid", int'(loc_valid), int'(mScan));
        checkOutput("busy", int'(busy), int'(mScan));
        checkOutput("cfg_err", int'(cfg_err), int'(mCfgErr));
        checkOutput("frame_done", int'(frame_done), int'(mFrameDone));
        checkOutput("loc_x", int'(loc_x), mX);
        checkOutput("loc_y", int'(loc_y), mY);
        checkOutput("row_last", int'(row_last), int'(mScan && (mIdx % mW == mW - 1)));
        checkOutput("frame_last", int'(frame_last), int'(mScan && (mIdx == mW * mH - 1)));
    endtask

    // One clock: drive inputs, advance the model, then check just after the edge
    task automatic applyStimulus(input bit rst, input bit st, input bit ab, input bit rdy);
        Reset = rst; start = st; abort = ab; loc_ready = rdy; mode = curMode;
        x_min = XB'(curXmin); x_max = XB'(curXmax);
        y_min = YB'(curYmin); y_max = YB'(curYmax);
        modelStep(rst, st, ab, rdy);
        @(posedge Clk);
        #1;
        checkAll();
    endtask

    task automatic setWindow(input int xa, input int xb, input int ya, input int yb, input bit md);
        curXmin = xa; curXmax = xb; curYmin = ya; curYmax = yb; curMode = md;
    endtask

    initial begin
        int expX[6] = '{2, 3, 4, 2, 3, 4};
        int expY[6] = '{1, 1, 1, 2, 2, 2};
        int dones;
        bit rdyPat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        mW = 1; mH = 1; mXmin = 0; mYmin = 0; mMode = 0;
        setWindow(0, 0, 0, 0, 1'b0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 1, 1);

        // Small window, single frame, always ready
        setWindow(2, 4, 1, 2, 1'b0);
        applyStimulus(0, 1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            checkOutput("seq_x", int'(loc_x), expX[i]);
            checkOutput("seq_y", int'(loc_y), expY[i]);
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("seq_done", int'(frame_done), 1);
        applyStimulus(0, 0, 0, 1);

        // Full-width rows, continuous, wrapping across two frames
        setWindow(0, PX - 1, PY - 3, PY - 1, 1'b1);
        applyStimulus(0, 1, 0, 1);
        dones = 0;
        for (int i = 0; i < 2 * PX * 3; i++) begin
            applyStimulus(0, 0, 0, 1);
            if (frame_done) dones++;
        end
        checkOutput("full_dones", dones, 2);
        applyStimulus(0, 0, 1, 1);

        // Two-location window with a stall
        setWindow(0, 1, 0, 0, 1'b0);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, rdyPat[i]);
        applyStimulus(0, 0, 0, 1);

        // Abort coinciding with the last accept in continuous mode
        setWindow(0, 1, 0, 0, 1'b1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1);

        // Illegal window then a legal restart
        setWindow(5, 3, 0, 0, 1'b0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1);
        setWindow(3, 5, 2, 2, 1'b0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);

        // Reset in the middle of a scan
        setWindow(2, 4, 1, 2, 1'b0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);

        // Randomized windows, handshakes, aborts and resets
        for (int t = 0; t < 50; t++) begin
            int w, h, xa, ya;
            w  = $urandom_range(1, 4);
            h  = $urandom_range(1, 3);
            xa = $urandom_range(0, PX - w);
            ya = $urandom_range(0, PY - h);
            case ($urandom_range(0, 7))
                0:       setWindow(xa + w - 1, xa, ya, ya + h - 1, 1'($urandom));
                1:       setWindow(xa, PX + $urandom_range(0, 300), ya, ya + h - 1, 1'($urandom));
                2:       setWindow(xa, xa + w - 1, ya, PY + $urandom_range(0, 20), 1'($urandom));
                default: setWindow(xa, xa + w - 1, ya, ya + h - 1, 1'($urandom));
            endcase
            applyStimulus(0, 1, 0, 1'($urandom));
            for (int c = 0; c < 30; c++) begin
                applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 14) == 0,
                              $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
